// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter for the register file write port, plus a pending-write scoreboard.
// Optional REGFILE_WB_ZERO_EN: register 0 is hardwired (never written, never pending).
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] left_addr,
    input  logic [ADDR_W-1:0] right_addr,
    output logic              operand_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              idle
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              prio_q, prio_d;   // 0 = port A preferred, 1 = port B
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DEPTH-1:0]  sb_q, sb_d, sb_vis;
    logic              a_acc, b_acc, issue_acc;

`ifdef REGFILE_WB_ZERO_EN
    assign sb_vis = sb_q & ~DEPTH'(1);
`else
    assign sb_vis = sb_q;
`endif

    assign a_ready       = !reset && (!b_valid || !prio_q);
    assign b_ready       = !reset && (!a_valid ||  prio_q);
    assign issue_ready   = !reset && !sb_vis[issue_addr];
    assign operand_stall = !reset && (sb_vis[left_addr] || sb_vis[right_addr]);
    assign idle          = !reset && (sb_q == '0) && !wr_en_q;

    assign a_acc     = a_valid && a_ready;
    assign b_acc     = b_valid && b_ready;
    assign issue_acc = issue_valid && issue_ready;

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    always_comb begin
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = a_addr;
            wr_data_d = a_data;
            prio_d    = 1'b1;
        end else if (b_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = b_addr;
            wr_data_d = b_data;
            prio_d    = 1'b0;
        end
`ifdef REGFILE_WB_ZERO_EN
        // Grant is still consumed; only the register-file write is suppressed.
        if (wr_addr_d == '0) wr_en_d = 1'b0;
`endif
    end

    // Clear first so a same-edge issue to the written register keeps it pending.
    always_comb begin
        sb_d = sb_q;
        if (wr_en_q)   sb_d[wr_addr_q]  = 1'b0;
        if (issue_acc) sb_d[issue_addr] = 1'b1;
`ifdef REGFILE_WB_ZERO_EN
        sb_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sb_q      <= '0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sb_q      <= sb_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: directed stimulus pushes expected write-backs, a monitor pops them on wr_en.
module tb_regfile_wb_scheduler;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_addr, b_addr, issue_addr, left_addr, right_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, issue_ready, operand_stall, wr_en, idle;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int  total = 0;
    int  bad   = 0;
    wb_t exp_q[$];

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .left_addr(left_addr), .right_addr(right_addr), .operand_stall(operand_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the oldest expected write-back.
    initial begin
        wb_t e;
        forever begin
            @(negedge clock);
            if (!reset && wr_en === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got addr %0d data %h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.a || wr_data !== e.d) begin
                        bad++;
                        $display("FAIL wb_data: got addr %0d data %h expected addr %0d data %h",
                                 wr_addr, wr_data, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333_3333;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        issue_valid = 1'b0; issue_addr = '0; left_addr = '0; right_addr = '0;

        // Reset behaviour
        step(); step();
        @(negedge clock);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_issue_ready", 32'(issue_ready), 0);
        chk("rst_idle", 32'(idle), 0);
        step();
        reset = 1'b0; a_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_wr_en", 32'(wr_en), 0);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_wr_addr", 32'(wr_addr), 0);

        // Issue 5, then write back 5; stall holds until the write edge
        step();
        issue_valid = 1'b1; issue_addr = 5'd5; left_addr = 5'd5; right_addr = 5'd6;
        @(negedge clock);
        chk("iss5_ready", 32'(issue_ready), 1);
        chk("iss5_stall_before", 32'(operand_stall), 0);
        step();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        push(5'd5, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("wb5_a_ready", 32'(a_ready), 1);
        chk("wb5_stall_pending", 32'(operand_stall), 1);
        chk("wb5_idle", 32'(idle), 0);
        step();
        a_valid = 1'b0;
        @(negedge clock);
        chk("wb5_wr_en", 32'(wr_en), 1);
        chk("wb5_stall_wr_cycle", 32'(operand_stall), 1);
        step();
        @(negedge clock);
        chk("wb5_stall_cleared", 32'(operand_stall), 0);
        chk("wb5_idle_after", 32'(idle), 1);

        // Single B transfer returns priority to A
        step();
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_0044;
        push(5'd4, 32'h0000_0044);
        @(negedge clock);
        chk("b_only_ready", 32'(b_ready), 1);

        // Contention: grants alternate A,B,A,B
        step();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(5'd1, 32'h1111_1111);
            else            push(5'd2, 32'h2222_2222);
            @(negedge clock);
            chk($sformatf("rr_a_ready%0d", i), 32'(a_ready), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_b_ready%0d", i), 32'(b_ready), (i % 2 == 0) ? 0 : 1);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // WAW: second issue to 7 blocked until the write-back commits
        issue_valid = 1'b1; issue_addr = 5'd7;
        @(negedge clock);
        chk("waw7_first", 32'(issue_ready), 1);
        step();
        @(negedge clock);
        chk("waw7_second", 32'(issue_ready), 0);
        step();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0077;
        push(5'd7, 32'h0000_0077);
        @(negedge clock);
        chk("waw7_during_accept", 32'(issue_ready), 0);
        step();
        a_valid = 1'b0;
        @(negedge clock);
        chk("waw7_wr_cycle", 32'(issue_ready), 0);
        step();
        @(negedge clock);
        chk("waw7_released", 32'(issue_ready), 1);
        step();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0078;
        push(5'd7, 32'h0000_0078);
        step();
        a_valid = 1'b0;
        step(); step();

        // Set wins over same-edge clear on register 9
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
        push(5'd9, 32'h0000_0099);
        step();
        a_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd9; left_addr = 5'd9;
        @(negedge clock);
        chk("sw9_issue_ready", 32'(issue_ready), 1);
        step();
        issue_valid = 1'b0;
        @(negedge clock);
        chk("sw9_stall", 32'(operand_stall), 1);
        chk("sw9_idle", 32'(idle), 0);
        step();
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_009A;
        push(5'd9, 32'h0000_009A);
        step();
        a_valid = 1'b0;
        step();
        @(negedge clock);
        chk("sw9_stall_cleared", 32'(operand_stall), 0);
        chk("sw9_idle_after", 32'(idle), 1);

        // Write-back to register 0
        step();
        left_addr = 5'd0; right_addr = 5'd0;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1234;
`ifndef REGFILE_WB_ZERO_EN
        push(5'd0, 32'h0000_1234);
`endif
        @(negedge clock);
        chk("zero_b_ready", 32'(b_ready), 1);
        step();
        b_valid = 1'b0;
        @(negedge clock);
`ifdef REGFILE_WB_ZERO_EN
        chk("zero_wr_en", 32'(wr_en), 0);
`else
        chk("zero_wr_en", 32'(wr_en), 1);
`endif
        step(); step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
